// File: rtl/muldiv_pkg.sv
// Shared M-extension definitions: FUNC3 op encodings, multiply/divide FSM states
// and operand-signedness helpers used by the decoder, ALU control and muldiv_unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_signed_a(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, sign fix-up in FINISH, abortable by FLUSH.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic            FLUSH,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OPERAND_A,
    input  logic [XLEN-1:0] OPERAND_B,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT,
    output muldiv_state_e   dbg_state_o
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    muldiv_op_e        in_op;
    logic              in_neg_a, in_neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;

    logic [XLEN:0]     mul_sum, rem_shift;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] step_next, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fin_result;

    always_comb begin
        in_op    = muldiv_op_e'(FUNC3);
        in_neg_a = op_signed_a(in_op) && OPERAND_A[XLEN-1];
        in_neg_b = op_signed_b(in_op) && OPERAND_B[XLEN-1];
        mag_a    = in_neg_a ? -OPERAND_A : OPERAND_A;
        mag_b    = in_neg_b ? -OPERAND_B : OPERAND_B;
        div_zero = op_is_div(in_op) && (OPERAND_B == '0);
        div_ovf  = (in_op == OP_DIV || in_op == OP_REM) &&
                   (OPERAND_A == MOST_NEG) && (OPERAND_B == '1);
    end

    // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_ge    = rem_shift >= {1'b0, opnd_q};
        rem_new   = rem_ge ? XLEN'(rem_shift - {1'b0, opnd_q}) : rem_shift[XLEN-1:0];
        if (op_is_div(op_q)) begin
            step_next = {rem_new, acc_q[XLEN-2:0], rem_ge};
        end else begin
            step_next = {mul_sum, acc_q[XLEN-1:1]};
        end

        prod_fix   = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot_fix   = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix    = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fin_result = rem_fix;
        case (op_q)
            OP_MUL:                      fin_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fin_result = quot_fix;
            default:                     fin_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    op_d    = in_op;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    if (div_zero) begin
                        result_d = (in_op inside {OP_DIV, OP_DIVU}) ? '1 : OPERAND_A;
                        done_d   = 1'b1;
                    end else if (div_ovf) begin
                        result_d = (in_op == OP_DIV) ? OPERAND_A : '0;
                        done_d   = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                        cnt_d   = CW'(XLEN);
                        opnd_d  = op_is_div(in_op) ? mag_b : mag_a;
                        acc_d   = {{XLEN{1'b0}}, (op_is_div(in_op) ? mag_a : mag_b)};
                    end
                end
            end
            ST_CALC: begin
                acc_d = step_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                result_d = fin_result;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything, including a same-cycle START.
        if (FLUSH) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign BUSY        = (state_q != ST_IDLE);
    assign DONE        = done_q;
    assign RESULT      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit (XLEN=32) against a plain-arithmetic
// model of the RISC-V M-extension, including latency, abort, reset and back-to-back.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int NORMAL_LAT = XLEN + 2;

    logic            CLK = 1'b0;
    logic            RESET_N = 1'b0;
    logic            START = 1'b0;
    logic            FLUSH = 1'b0;
    logic [2:0]      FUNC3 = 3'b000;
    logic [XLEN-1:0] OPERAND_A = '0;
    logic [XLEN-1:0] OPERAND_B = '0;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;
    muldiv_state_e   dbg_state;

    int n_checks = 0;
    int n_pass = 0;
    logic [XLEN-1:0] exp_q[$];

    muldiv_unit #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .FLUSH(FLUSH), .FUNC3(FUNC3),
        .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B), .BUSY(BUSY), .DONE(DONE),
        .RESULT(RESULT), .dbg_state_o(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M semantics with 64-bit integer arithmetic.
    function automatic logic [XLEN-1:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                                  input logic [31:0] b);
        longint sa, sb, ub_s;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        ub_s = longint'(ub);
        p    = '0;
        case (f)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub_s; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return '1;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return NORMAL_LAT;
    endfunction

    // Called at a negedge; START is raised for the coming edge (cycle 0). Returns at the
    // negedge of the DONE cycle, so a following call issues a back-to-back START.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int lat;
        int exp_lat;
        bit busy_ok;
        logic [XLEN-1:0] want;
        exp_lat = ref_latency(f, a, b);
        exp_q.push_back(exp);
        START = 1'b1; FUNC3 = f; OPERAND_A = a; OPERAND_B = b;
        @(negedge CLK);
        lat = 1;
        busy_ok = 1'b1;
        while (DONE !== 1'b1 && lat < 100) begin
            if (BUSY !== 1'b1) busy_ok = 1'b0;
            // Stray requests and changing operands must not disturb the running op.
            START = 1'($urandom_range(0, 1));
            FUNC3 = 3'($urandom); OPERAND_A = $urandom; OPERAND_B = $urandom;
            @(negedge CLK);
            lat++;
        end
        START = 1'b0;
        want = exp_q.pop_front();
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".result"}, 64'(RESULT), 64'(want));
        check({tag, ".busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, ".busy_at_done"}, 64'(BUSY), 64'd0);
    endtask

    task automatic idle_watch(input int cycles, input string tag, input logic [31:0] exp_result);
        bit seen_done;
        bit seen_busy;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (DONE !== 1'b0) seen_done = 1'b1;
            if (BUSY !== 1'b0) seen_busy = 1'b1;
        end
        check({tag, ".no_done"}, 64'(seen_done), 64'd0);
        check({tag, ".no_busy"}, 64'(seen_busy), 64'd0);
        check({tag, ".result_held"}, 64'(RESULT), 64'(exp_result));
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int sel;

        // Reset overrides START and FLUSH.
        START = 1'b1; FLUSH = 1'b1; FUNC3 = 3'b101; OPERAND_B = '0;
        repeat (3) @(negedge CLK);
        check("reset.busy", 64'(BUSY), 64'd0);
        check("reset.done", 64'(DONE), 64'd0);
        check("reset.result", 64'(RESULT), 64'd0);
        RESET_N = 1'b1; START = 1'b0; FLUSH = 1'b0;
        @(negedge CLK);

        // Directed values, issued back-to-back.
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_neg");
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_minmin");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_max");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_neg7_2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_neg7_2");
        run_op(3'b101, 32'd100, 32'd7, 32'd14, "divu_100_7");
        run_op(3'b111, 32'd100, 32'd7, 32'd2, "remu_100_7");
        run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by_zero");
        run_op(3'b111, 32'd5, 32'd0, 32'd5, "remu_by_zero");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_overflow");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_again");
        idle_watch(4, "after_b2b", 32'hFFFF_FFFE);

        // Flush at cycle 10 of a MUL, restart at cycle 11.
        START = 1'b1; FUNC3 = 3'b000; OPERAND_A = 32'd1234; OPERAND_B = 32'd5678;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        check("flush.busy", 64'(BUSY), 64'd0);
        check("flush.done", 64'(DONE), 64'd0);
        check("flush.result", 64'(RESULT), 64'h0000_0000_FFFF_FFFE);
        run_op(3'b000, 32'd3, 32'd5, 32'd15, "after_flush");

        // FLUSH beats a same-cycle START, even one that would take the fast path.
        START = 1'b1; FLUSH = 1'b1; FUNC3 = 3'b101; OPERAND_A = 32'd9; OPERAND_B = 32'd0;
        @(negedge CLK);
        START = 1'b0; FLUSH = 1'b0;
        check("flush_start.done", 64'(DONE), 64'd0);
        idle_watch(3, "flush_start", 32'd15);

        // Reset at cycle 5 of a MUL.
        START = 1'b1; FUNC3 = 3'b000; OPERAND_A = 32'd77; OPERAND_B = 32'd99;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        check("midreset.busy", 64'(BUSY), 64'd0);
        check("midreset.result", 64'(RESULT), 64'd0);
        idle_watch(40, "midreset", 32'd0);

        // Randomized operations with corner-case bias and occasional idle gaps.
        for (int n = 0; n < 48; n++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 255));
                4: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(f, a, b, ref_model(f, a, b), $sformatf("rand%0d_f%0d", n, f));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge CLK);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width; legal values 8..64, even.
REQ-002 SHALL have port CLK, input, 1: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port RESET_N, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port START, input, 1: request; sampled only in IDLE.
REQ-005 SHALL have port FLUSH, input, 1: abort of any in-flight operation.
REQ-006 SHALL have port FUNC3, input, 3: M-extension op (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 SHALL have ports OPERAND_A and OPERAND_B, input, XLEN: rs1 (multiplicand/dividend) and rs2 (multiplier/divisor).
REQ-008 SHALL have port BUSY, output, 1: high while not in IDLE.
REQ-009 SHALL have port DONE, output, 1: single-cycle pulse marking RESULT valid.
REQ-010 SHALL have port RESULT, output, XLEN: result of the last completed operation.

Function
REQ-011 SHALL implement an FSM with states IDLE, CALC, FINISH.
REQ-012 SHALL, in IDLE with START=1 and FLUSH=0, capture FUNC3 and both operands, load the iteration counter with XLEN, and enter CALC (acceptance cycle = cycle 0).
REQ-013 SHALL ignore START while BUSY=1; captured operands SHALL not change during an operation.
REQ-014 SHALL operate on operand magnitudes per op signedness (MULH/DIV/REM: both signed; MULHSU: A signed, B unsigned; others unsigned).
REQ-015 SHALL perform multiply as radix-2 shift-add into a 2*XLEN product, and divide as radix-2 restoring division, one bit per CALC cycle.
REQ-016 SHALL leave CALC for FINISH when the counter reaches 0 after XLEN iterations.
REQ-017 SHALL, in FINISH, apply sign correction (product sign = sign A xor sign B; quotient sign = sign A xor sign B; remainder sign = sign A), then select the low half (MUL), high half (MULH/MULHSU/MULHU), quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-018 SHALL register RESULT and pulse DONE=1 in the cycle after FINISH, returning to IDLE in that same cycle; normal latency is DONE at cycle XLEN+2.
REQ-019 SHALL take a fast path for divide-by-zero (B=0, ops 100..111), skipping CALC, with DONE at cycle 1: quotient all ones, remainder = A.
REQ-020 SHALL take a fast path for signed overflow (DIV/REM, A=most-negative, B=all ones), with DONE at cycle 1: quotient = A, remainder = 0.
REQ-021 SHALL hold RESULT stable from DONE until the next DONE.
REQ-022 SHALL, on FLUSH=1 in any state, go to IDLE next cycle with DONE suppressed and RESULT unchanged.
REQ-023 SHALL give FLUSH priority over a same-cycle START, which is dropped.
REQ-024 SHALL accept a new START in the cycle DONE is high (BUSY=0 in that cycle), giving back-to-back operation.

Reset
REQ-025 SHALL, on RESET_N=0 at a clock edge, force IDLE, BUSY=0, DONE=0, RESULT=0 and counter=0, overriding START and FLUSH.
REQ-026 SHALL, on reset mid-operation, discard the operation with no DONE pulse afterwards.

Structure
REQ-027 SHALL take FUNC3 M-op encodings and the FSM state type from the shared package muldiv_pkg, shared with the ALU control unit and decoder.
REQ-028 SHALL be a single module with no sub-modules; the counter width SHALL be $clog2(XLEN+1).

Verification (XLEN=32)
REQ-029 SHALL check MUL A=7, B=0xFFFFFFFD: RESULT=0xFFFFFFEB, DONE at cycle 34, BUSY cycles 1..33.
REQ-030 SHALL check the high multiplies: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 SHALL check signed divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-032 SHALL check the corner cases: DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, DONE at cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, DONE at cycle 1.
REQ-033 SHALL check abort: FLUSH at cycle 10 of a MUL gives BUSY=0 at cycle 11, no DONE, and RESULT unchanged; a START at cycle 11 completes correctly.
REQ-034 SHALL check reset and back-to-back: RESET_N low at cycle 5 gives BUSY=0 and RESULT=0, then no DONE; START asserted in the DONE cycle is accepted.
